// File: rtl/ifetch_seq.sv
// ifetch_seq: two-state (IDLE/REQ) instruction fetch sequencer driving pc.in/pc.we.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned start raises sticky fault instead of masking.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

module ifetch_seq #(
    parameter int ADDR_W = `ADDR_LEN,
    parameter int INSN_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_cur,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_we,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic [INSN_W-1:0] ir,
    output logic              ir_valid,
    output logic              busy,
    output logic              fault
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] tgt, tgt_n;
    logic [ADDR_W-1:0] pc_next_n, addr_n;
    logic [INSN_W-1:0] ir_n;
    logic              flush, flush_n;
    logic              pc_we_n, req_n, irv_n, fault_n;
    logic [ADDR_W-1:0] fetch_addr;
    logic              start_ok, start_bad;

    assign fetch_addr = pc_cur & ~ADDR_W'(3);

`ifdef IFETCH_ALIGN_CHECK_EN
    assign start_ok  = start && !fault && (pc_cur[1:0] == 2'b00);
    assign start_bad = start && (pc_cur[1:0] != 2'b00);
`else
    assign start_ok  = start;
    assign start_bad = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_n   = state;
        tgt_n     = tgt;
        flush_n   = flush;
        pc_next_n = pc_next;
        addr_n    = imem_addr;
        ir_n      = ir;
        fault_n   = fault;
        pc_we_n   = 1'b0;
        req_n     = 1'b0;
        irv_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (redirect) begin
                    pc_next_n = redirect_addr;
                    pc_we_n   = 1'b1;
                end else if (start_ok) begin
                    addr_n  = fetch_addr;
                    req_n   = 1'b1;
                    state_n = REQ;
                end else begin
                    fault_n = fault | start_bad;
                end
            end
            REQ: begin
                req_n = 1'b1;
                if (redirect) begin
                    flush_n = 1'b1;
                    tgt_n   = redirect_addr;
                end
                if (imem_ack) begin
                    req_n   = 1'b0;
                    pc_we_n = 1'b1;
                    flush_n = 1'b0;
                    state_n = IDLE;
                    // A redirect on the ack cycle itself still squashes this fetch
                    if (redirect) begin
                        pc_next_n = redirect_addr;
                    end else if (flush) begin
                        pc_next_n = tgt;
                    end else begin
                        ir_n      = imem_rdata;
                        irv_n     = 1'b1;
                        pc_next_n = imem_addr + ADDR_W'(4);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tgt       <= '0;
            flush     <= 1'b0;
            pc_next   <= '0;
            pc_we     <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            tgt       <= tgt_n;
            flush     <= flush_n;
            pc_next   <= pc_next_n;
            pc_we     <= pc_we_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            ir        <= ir_n;
            ir_valid  <= irv_n;
            fault     <= fault_n;
        end
    end

endmodule

// File: doc/ifetch_seq.md
# ifetch_seq

Multi-cycle instruction fetch sequencer. It reads the current value of the `pc` register and fetches the instruction at that address over a request/acknowledge instruction-memory port. It loads the instruction register, then drives the `pc` write port (`in`/`we`) with the next sequential address or with a pending branch/jump target. It sits between the multi-cycle control FSM, the `pc` register and instruction memory.

## Interface
- `ADDR_W`, default `` `ADDR_LEN `` (32): address width.
- `INSN_W`, default 32: instruction width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  fetch request from control FSM; sampled only in IDLE.
- `pc_cur`  in  ADDR_W  current PC (from `pc.out`).
- `redirect`  in  1  one-cycle branch/jump strobe.
- `redirect_addr`  in  ADDR_W  branch/jump target, valid with `redirect`.
- `pc_next`  out  ADDR_W  value for `pc.in`.
- `pc_we`  out  1  one-cycle write strobe for `pc.we`.
- `imem_req`  out  1  memory read request.
- `imem_addr`  out  ADDR_W  memory read address.
- `imem_ack`  in  1  memory acknowledge, with data valid.
- `imem_rdata`  in  INSN_W  memory read data.
- `ir`  out  INSN_W  instruction register.
- `ir_valid`  out  1  one-cycle pulse when `ir` is updated.
- `busy`  out  1  high whenever state ≠ IDLE.
- `fault`  out  1  sticky misaligned-fetch flag (see Configuration).

## Operation
States:
- **IDLE**
  - `redirect`=1: `pc_next`←`redirect_addr`, `pc_we` pulses next cycle, stay in IDLE. `start` in the same cycle is dropped; the FSM must re-issue it.
  - else `start`=1: latch `pc_cur` into `imem_addr`, go to REQ.
- **REQ**
  - `imem_req`=1; `imem_addr` is held stable until ack.
  - `redirect` in REQ, including the ack cycle: set the flush flag and store `redirect_addr`. A later redirect overwrites the stored target (last wins).
  - On `imem_ack`:
    - no flush: `ir`←`imem_rdata`, `ir_valid` pulses, `pc_next`←`imem_addr`+4.
    - flush: `ir` is unchanged, `ir_valid`=0, `pc_next`←stored target.
    - In both cases `pc_we` pulses, the flush flag clears, and the FSM returns to IDLE.
- Arithmetic: `imem_addr`+4 is modulo 2^ADDR_W, so 0xFFFFFFFC → 0x00000000.
- All outputs are registered, except `busy`, which is decoded from state.
- Reset:
  - state=IDLE; `pc_next`, `imem_addr`, `ir` = 0; `pc_we`, `imem_req`, `ir_valid`, `fault` = 0; flush flag cleared.
  - Reset during REQ drops `imem_req` immediately (asynchronously). A late `imem_ack` after reset release is ignored in IDLE.
- `imem_ack` outside REQ is ignored.

## Timing
- `start` sampled at edge t → `imem_req`=1 from t+1.
- Ack sampled at edge a (a ≥ t+1) → `ir`, `ir_valid`, `pc_next` and `pc_we` all take effect at a+1. `imem_req`=0 at a+1.
- Minimum start-to-`ir_valid` latency is 2 cycles (zero-wait ack).
- `pc_we` and `ir_valid` are never high for more than one cycle.
- The PC register updates at a+2, so the earliest back-to-back `start` is accepted at a+1, in IDLE. `pc_cur` must already hold the updated value when `start` is sampled.
- A redirect in IDLE at edge r → `pc_we`=1 at r+1.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - A `start` in IDLE with `pc_cur[1:0]`≠0 issues no request, stays in IDLE, and sets `fault`=1 at the next edge.
  - `fault` is cleared only by reset. While `fault`=1, every `start` is ignored; `redirect` is still honoured.
- Undefined:
  - `imem_addr` is latched with bits [1:0] forced to 0, and `fault` is tied to 0.

## Test plan
- Reset: assert `rst_n`=0 mid-REQ → `imem_req` drops without a clock edge; all outputs read 0 and `busy`=0 after release.
- Basic fetch: `pc_cur`=0x100, `start`; ack after 3 wait cycles with `imem_rdata`=0x00A00093 → `ir`=0x00A00093, one-cycle `ir_valid` and `pc_we`, `pc_next`=0x104.
- Zero-wait fetch: ack in the first REQ cycle → `ir_valid` exactly 2 cycles after `start`. Back-to-back fetches 0x104 then 0x108 complete correctly.
- Flush: during REQ at 0x100, apply `redirect` 0x200 then 0x300 → on ack, `ir_valid`=0, `ir` unchanged, `pc_next`=0x300, `pc_we`=1.
- Wrap and collision: `pc_cur`=0xFFFFFFFC fetch → `pc_next`=0x00000000. In IDLE, `start` and `redirect`(0x40) together → no `imem_req`, `pc_next`=0x40.
- Misaligned `pc_cur`=0x102:
  - with `IFETCH_ALIGN_CHECK_EN` → `fault`=1 and no request; a subsequent `start` at 0x104 is ignored.
  - without it → fetch from 0x100, `pc_next`=0x104.
